// File: rtl/handshake_pkg.sv
// Shared definitions for the dav_/rfd parallel handshake (reader now, writer later).
package handshake_pkg;

  typedef enum logic [0:0] {
    ST_READY        = 1'b0,
    ST_WAIT_RELEASE = 1'b1
  } hs_state_e;

  // dav_ is active low, rfd is active high
  localparam logic DAV_ASSERTED   = 1'b0;
  localparam logic DAV_RELEASED   = 1'b1;
  localparam logic RFD_ASSERTED   = 1'b1;
  localparam logic RFD_DEASSERTED = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/handshake_byte_reader.sv
// Consumer side of the dav_/rfd handshake: captures each producer byte once into a FIFO
// and presents it on valid/ready. Define PARITY_CHECK_EN to add the parity port and sticky par_err.
module handshake_byte_reader
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             dav_,
  input  logic [WIDTH-1:0] data,
`ifdef PARITY_CHECK_EN
  input  logic             parity,
  output logic             par_err,
`endif
  output logic             rfd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             dav_s;
  hs_state_e        state, state_nxt;
  logic [1:0]       settle;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_valid_nxt;
  logic             rfd_nxt;
  logic             push_c, pop_c, full_c, settled_c;

  sync_2ff #(.RESET_VAL(DAV_RELEASED)) u_dav_sync (
    .clk   (clock),
    .rst_n (reset_),
    .d     (dav_),
    .q     (dav_s)
  );

  // Next-state, FIFO bookkeeping and next output values
  always_comb begin
    state_nxt     = state;
    push_c        = 1'b0;
    full_c        = (count == CNT_W'(DEPTH));
    pop_c         = out_valid && out_ready;
    // The synchronizer outputs its reset value until two real samples have passed
    settled_c     = settle[1];

    case (state)
      ST_READY: begin
        if (dav_s == DAV_ASSERTED && !full_c) begin
          push_c    = 1'b1;
          state_nxt = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (dav_s == DAV_RELEASED && settled_c) begin
          state_nxt = ST_READY;
        end
      end
      default: state_nxt = ST_WAIT_RELEASE;
    endcase

    wr_ptr_nxt    = wr_ptr + PTR_W'(push_c);
    rd_ptr_nxt    = rd_ptr + PTR_W'(pop_c);
    count_nxt     = count + CNT_W'(push_c) - CNT_W'(pop_c);
    out_valid_nxt = (count_nxt != '0);
    rfd_nxt       = (state_nxt == ST_READY && count_nxt != CNT_W'(DEPTH)) ? RFD_ASSERTED
                                                                          : RFD_DEASSERTED;

    // A byte pushed into an otherwise empty FIFO becomes the head directly
    if (push_c && (count - CNT_W'(pop_c)) == '0) begin
      out_data_nxt = data;
    end else begin
      out_data_nxt = mem[rd_ptr_nxt];
    end
  end

  // State, pointers and registered outputs
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state     <= ST_WAIT_RELEASE;
      settle    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rfd       <= RFD_DEASSERTED;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      settle    <= {settle[0], 1'b1};
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      rfd       <= rfd_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_c) begin
      mem[wr_ptr] <= data;
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky even-parity error; the byte is still delivered
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      par_err <= 1'b0;
    end else if (push_c && (^{data, parity})) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_byte_reader.sv
// Bench for handshake_byte_reader: queue-based reference model plus directed handshakes.
// Define PARITY_CHECK_EN to also exercise the parity port.
module tb_handshake_byte_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clock;
  logic             reset_;
  logic             dav_;
  logic [WIDTH-1:0] data;
  logic             rfd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef PARITY_CHECK_EN
  logic             parity;
  logic             par_err;
`endif

  int checks = 0;
  int fails  = 0;

  handshake_byte_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .dav_      (dav_),
    .data      (data),
`ifdef PARITY_CHECK_EN
    .parity    (parity),
    .par_err   (par_err),
`endif
    .rfd       (rfd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: dav_ seen two edges late, one capture per low pulse, FIFO as a queue
  logic [WIDTH-1:0] q[$];
  logic             h0 = 1'b1, h1 = 1'b1;
  logic             m_eligible = 1'b0;
  int               m_edges = 0;
  logic             m_par = 1'b0;

  always @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q.delete();
      h0         <= 1'b1;
      h1         <= 1'b1;
      m_eligible <= 1'b0;
      m_edges    <= 0;
      m_par      <= 1'b0;
    end else begin
      automatic logic seen_dav = h1;
      automatic logic full     = (q.size() == DEPTH);
      automatic logic pop      = (q.size() != 0) && out_ready;
      automatic logic push     = m_eligible && !seen_dav && !full;
      if (push) m_eligible <= 1'b0;
      else if (!m_eligible && seen_dav && m_edges >= 2) m_eligible <= 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(data);
`ifdef PARITY_CHECK_EN
      if (push && (^{data, parity})) m_par <= 1'b1;
`endif
      h1 <= h0;
      h0 <= dav_;
      if (m_edges < 2) m_edges <= m_edges + 1;
    end
  end

  // Every byte the DUT hands downstream, in order
  logic [WIDTH-1:0] rx[$];
  always @(posedge clock) begin
    if (reset_ && out_valid && out_ready) rx.push_back(out_data);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_rfd", 32'(rfd), 32'(m_eligible && (q.size() < DEPTH)));
    check("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("model_out_data", 32'(out_data), 32'(q[0]));
`ifdef PARITY_CHECK_EN
    check("model_par_err", 32'(par_err), 32'(m_par));
`endif
  endtask

  task automatic tick();
    @(negedge clock);
    compare_model();
  endtask

  task automatic wait_rfd(input logic v, input int budget, input string nm);
    int n = 0;
    while (rfd !== v && n < budget) begin
      tick();
      n++;
    end
    check(nm, 32'(rfd), 32'(v));
  endtask

  task automatic handshake(input logic [WIDTH-1:0] d);
    wait_rfd(1'b1, 40, "hs_rfd_ready");
    data = d;
`ifdef PARITY_CHECK_EN
    parity = ^d;
`endif
    dav_ = 1'b0;
    wait_rfd(1'b0, 20, "hs_rfd_ack");
    dav_ = 1'b1;
  endtask

  logic [WIDTH-1:0] exp_rx [18] = '{8'hA5, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                    8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23,
                                    8'h24, 8'h25, 8'h26, 8'h27};

  initial begin
    dav_      = 1'b1;
    data      = '0;
    out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    parity    = 1'b0;
`endif
    reset_    = 1'b1;
    #2;
    reset_    = 1'b0;
    repeat (3) tick();
    check("reset_rfd", 32'(rfd), 32'(0));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out_data", 32'(out_data), 32'(0));
    reset_ = 1'b1;

    // Single byte, three-edge latency to rfd
    out_ready = 1'b1;
    wait_rfd(1'b1, 10, "startup_rfd");
    data = 8'hA5;
    dav_ = 1'b0;
    tick();
    tick();
    check("t1_rfd_after_2_edges", 32'(rfd), 32'(1));
    tick();
    check("t1_rfd_after_3_edges", 32'(rfd), 32'(0));
    check("t1_out_valid", 32'(out_valid), 32'(1));
    check("t1_out_data", 32'(out_data), 32'hA5);
    tick();
    check("t1_popped", 32'(out_valid), 32'(0));
    dav_ = 1'b1;

    // Long dav_ pulse yields one byte
    out_ready = 1'b0;
    wait_rfd(1'b1, 10, "t2_rfd_ready");
    data = 8'h3C;
    dav_ = 1'b0;
    repeat (20) tick();
    dav_ = 1'b1;
    repeat (4) tick();
    check("t2_out_valid", 32'(out_valid), 32'(1));
    check("t2_out_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    tick();
    check("t2_single_push", 32'(out_valid), 32'(0));
    out_ready = 1'b0;

    // Fill to DEPTH, fifth producer byte stalls until space frees
    for (int i = 1; i <= 4; i++) handshake(WIDTH'(i));
    repeat (4) tick();
    check("t3_full_rfd", 32'(rfd), 32'(0));
    data = 8'h05;
    dav_ = 1'b0;
    repeat (6) tick();
    check("t3_stalled_rfd", 32'(rfd), 32'(0));
    check("t3_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    repeat (12) tick();
    dav_ = 1'b1;
    repeat (4) tick();
    check("t3_drained", 32'(out_valid), 32'(0));
    out_ready = 1'b0;

    // Push and pop on the same edge at count 2, then stream past pointer wrap
    handshake(8'h10);
    handshake(8'h11);
    wait_rfd(1'b1, 10, "t4_rfd_ready");
    data = 8'h12;
    dav_ = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_rfd_pushed", 32'(rfd), 32'(0));
    check("t4_head_after_pop", 32'(out_data), 32'h11);
    dav_ = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) handshake(WIDTH'(8'h20 + i));
    repeat (6) tick();
    out_ready = 1'b0;
    check("rx_count", 32'(rx.size()), 32'(18));
    for (int i = 0; i < 18; i++) begin
      if (i < rx.size()) check($sformatf("rx_order_%0d", i), 32'(rx[i]), 32'(exp_rx[i]));
    end

    // Reset with two bytes queued and dav_ held low
    handshake(8'h30);
    handshake(8'h31);
    wait_rfd(1'b1, 10, "t5_rfd_ready");
    data = 8'h32;
    dav_ = 1'b0;
    tick();
    reset_ = 1'b0;
    tick();
    tick();
    check("t5_reset_out_valid", 32'(out_valid), 32'(0));
    check("t5_reset_rfd", 32'(rfd), 32'(0));
    reset_ = 1'b1;
    repeat (10) tick();
    check("t5_no_recapture_valid", 32'(out_valid), 32'(0));
    check("t5_no_recapture_rfd", 32'(rfd), 32'(0));
    dav_ = 1'b1;
    wait_rfd(1'b1, 10, "t5_rfd_after_release");
    handshake(8'h33);
    tick();
    check("t5_new_out_valid", 32'(out_valid), 32'(1));
    check("t5_new_out_data", 32'(out_data), 32'h33);
    out_ready = 1'b1;
    tick();
    check("t5_rx_count", 32'(rx.size()), 32'(19));
    if (rx.size() == 19) check("t5_rx_byte", 32'(rx[18]), 32'h33);

`ifdef PARITY_CHECK_EN
    // Bad parity sets a sticky flag but the byte is kept
    wait_rfd(1'b1, 10, "t6_rfd_ready");
    data   = 8'h01;
    parity = 1'b0;
    dav_   = 1'b0;
    wait_rfd(1'b0, 20, "t6_rfd_ack");
    check("t6_par_err_set", 32'(par_err), 32'(1));
    check("t6_byte_kept", 32'(out_data), 32'h01);
    dav_ = 1'b1;
    handshake(8'h02);
    repeat (4) tick();
    check("t6_par_err_sticky", 32'(par_err), 32'(1));
    reset_ = 1'b0;
    tick();
    check("t6_par_err_reset", 32'(par_err), 32'(0));
    reset_ = 1'b1;
    repeat (3) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
